// File: rtl/foo_collect_pkg.sv
// Shared constants, holder record type and round-robin helper for foo_intf_collector.
package foo_collect_pkg;

  localparam int unsigned DEFAULT_NUM_LANES = 4;
  localparam int unsigned DEFAULT_DATA_W    = 8;

  typedef struct packed {
    logic                      vld;
    logic [DEFAULT_DATA_W-1:0] data;
  } hold_t;

  // Pointer to the lane after ptr, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/foo_rx_intf.sv
// Producer-to-collector lane: valid/data forward, ready back.
// Carries an extra par bit when FOO_COLLECT_PARITY_EN is defined.
interface foo_rx_intf #(
  parameter int unsigned DATA_W = 8
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;
`ifdef FOO_COLLECT_PARITY_EN
  logic              par;
`endif

  modport sink (
    input  valid,
    input  data,
`ifdef FOO_COLLECT_PARITY_EN
    input  par,
`endif
    output ready
  );

  modport source (
    output valid,
    output data,
`ifdef FOO_COLLECT_PARITY_EN
    output par,
`endif
    input  ready
  );
endinterface

// File: rtl/foo_lane_hold.sv
// One-entry holding register for a single collector lane; ready is derived from state only.
// FOO_COLLECT_PARITY_EN adds a stored parity bit and a mismatch flag.
module foo_lane_hold
  import foo_collect_pkg::*;
#(
  parameter int unsigned DataW = DEFAULT_DATA_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [DataW-1:0] data_i,
`ifdef FOO_COLLECT_PARITY_EN
  input  logic             par_i,
  output logic             par_err_o,
`endif
  input  logic             grant_i,
  output logic             ready_o,
  output logic             vld_o,
  output logic [DataW-1:0] data_o
);

  logic             vld_d, vld_q;
  logic [DataW-1:0] data_d, data_q;
`ifdef FOO_COLLECT_PARITY_EN
  logic             par_d, par_q;
`endif

  assign ready_o = rst_ni && !vld_q;
  assign vld_o   = vld_q;
  assign data_o  = data_q;

  // Capture and grant are mutually exclusive: capture needs an empty holder, grant a full one.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
`ifdef FOO_COLLECT_PARITY_EN
    par_d  = par_q;
`endif
    if (valid_i && ready_o) begin
      vld_d  = 1'b1;
      data_d = data_i;
`ifdef FOO_COLLECT_PARITY_EN
      par_d  = par_i;
`endif
    end else if (grant_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= 1'b0;
      data_q <= '0;
`ifdef FOO_COLLECT_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
`ifdef FOO_COLLECT_PARITY_EN
      par_q  <= par_d;
`endif
    end
  end

`ifdef FOO_COLLECT_PARITY_EN
  assign par_err_o = vld_q && ((^data_q) != par_q);
`endif

endmodule

// File: rtl/foo_intf_collector.sv
// Collects an array of foo_rx_intf lanes and serializes them round-robin onto one output stream.
// Optional parity checking/generation is enabled with FOO_COLLECT_PARITY_EN.
module foo_intf_collector
  import foo_collect_pkg::*;
#(
  parameter  int unsigned NUM_LANES = DEFAULT_NUM_LANES,
  parameter  int unsigned DATA_W    = DEFAULT_DATA_W,
  localparam int unsigned LANE_W    = $clog2(NUM_LANES > 1 ? NUM_LANES : 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  foo_rx_intf.sink          foos [0:NUM_LANES-1],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LANE_W-1:0] out_lane,
`ifdef FOO_COLLECT_PARITY_EN
  output logic              out_par,
  output logic              par_err,
`endif
  output logic              busy
);

  logic [NUM_LANES-1:0] hold_vld;
  logic [NUM_LANES-1:0] grant_vec;
  logic [DATA_W-1:0]    hold_data [NUM_LANES];
`ifdef FOO_COLLECT_PARITY_EN
  logic [NUM_LANES-1:0] lane_err;
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    foo_lane_hold #(
      .DataW(DATA_W)
    ) u_hold (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .valid_i   (foos[i].valid),
      .data_i    (foos[i].data),
`ifdef FOO_COLLECT_PARITY_EN
      .par_i     (foos[i].par),
      .par_err_o (lane_err[i]),
`endif
      .grant_i   (grant_vec[i]),
      .ready_o   (foos[i].ready),
      .vld_o     (hold_vld[i]),
      .data_o    (hold_data[i])
    );
  end

  logic              out_valid_d, out_valid_q;
  logic [DATA_W-1:0] out_data_d, out_data_q;
  logic [LANE_W-1:0] out_lane_d, out_lane_q;
  logic [LANE_W-1:0] rr_ptr_d, rr_ptr_q;
`ifdef FOO_COLLECT_PARITY_EN
  logic              out_par_d, out_par_q;
  logic              par_err_d, par_err_q;
`endif

  logic              slot_free;
  logic              found;
  logic [LANE_W-1:0] gnt_idx;
  int unsigned       scan;

  assign slot_free = !out_valid_q || out_ready;

  // First full holder at or after rr_ptr, wrapping modulo NUM_LANES.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    scan    = 0;
    for (int unsigned off = 0; off < NUM_LANES; off++) begin
      scan = 32'(rr_ptr_q) + off;
      if (scan >= NUM_LANES) begin
        scan = scan - NUM_LANES;
      end
      if (!found && hold_vld[LANE_W'(scan)]) begin
        found   = 1'b1;
        gnt_idx = LANE_W'(scan);
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      grant_vec[i] = slot_free && found && (gnt_idx == LANE_W'(i));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef FOO_COLLECT_PARITY_EN
    out_par_d   = out_par_q;
    par_err_d   = par_err_q | (|lane_err);
`endif
    if (slot_free) begin
      if (found) begin
        out_valid_d = 1'b1;
        out_data_d  = hold_data[gnt_idx];
        out_lane_d  = gnt_idx;
        rr_ptr_d    = LANE_W'(rr_next(32'(gnt_idx), NUM_LANES));
`ifdef FOO_COLLECT_PARITY_EN
        out_par_d   = ^hold_data[gnt_idx];
`endif
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
      rr_ptr_q    <= '0;
`ifdef FOO_COLLECT_PARITY_EN
      out_par_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef FOO_COLLECT_PARITY_EN
      out_par_q   <= out_par_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lane  = out_lane_q;
  assign busy      = (|hold_vld) || out_valid_q;
`ifdef FOO_COLLECT_PARITY_EN
  assign out_par   = out_par_q;
  assign par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_foo_intf_collector.sv
// Self-checking bench for foo_intf_collector: directed table, corner sequences, random vs. model.
module tb_foo_intf_collector;
  import foo_collect_pkg::*;

  localparam int NL = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic          busy;
  logic [DW-1:0] out_data;
  logic [1:0]    out_lane;
  logic [NL-1:0] v = '0;
  logic [NL-1:0] rdy;
  logic [DW-1:0] d [NL];
`ifdef FOO_COLLECT_PARITY_EN
  logic [NL-1:0] p_flip = '0;
  logic          out_par;
  logic          par_err;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  foo_rx_intf #(.DATA_W(DW)) foos [0:NL-1] ();

  for (genvar i = 0; i < NL; i++) begin : g_drv
    assign foos[i].valid = v[i];
    assign foos[i].data  = d[i];
    assign rdy[i]        = foos[i].ready;
`ifdef FOO_COLLECT_PARITY_EN
    assign foos[i].par   = (^d[i]) ^ p_flip[i];
`endif
  end

  foo_intf_collector #(
    .NUM_LANES(NL),
    .DATA_W   (DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .foos     (foos),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_lane (out_lane),
`ifdef FOO_COLLECT_PARITY_EN
    .out_par  (out_par),
    .par_err  (par_err),
`endif
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: holders as records, output slot, plain integer round-robin pointer.
  hold_t      m_hold [NL];
  logic       m_ov;
  logic [7:0] m_od;
  int         m_ol;
  int         m_ptr;

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_hold[i] = '0;
    m_ov = 1'b0; m_od = '0; m_ol = 0; m_ptr = 0;
  endtask

  task automatic model_edge();
    logic [NL-1:0] cap;
    int g;
    for (int i = 0; i < NL; i++) cap[i] = v[i] && !m_hold[i].vld;
    if (!m_ov || out_ready) begin
      g = -1;
      for (int k = 0; k < NL; k++)
        if (g < 0 && m_hold[(m_ptr + k) % NL].vld) g = (m_ptr + k) % NL;
      if (g >= 0) begin
        m_ov = 1'b1; m_od = m_hold[g].data; m_ol = g;
        m_hold[g].vld = 1'b0;
        m_ptr = (g + 1) % NL;
      end else begin
        m_ov = 1'b0;
      end
    end
    for (int i = 0; i < NL; i++)
      if (cap[i]) begin
        m_hold[i].vld  = 1'b1;
        m_hold[i].data = d[i];
      end
  endtask

  task automatic chk_model();
    logic [NL-1:0] er;
    logic anyf;
    anyf = 1'b0;
    for (int i = 0; i < NL; i++) begin
      er[i] = !m_hold[i].vld;
      anyf  = anyf | m_hold[i].vld;
    end
    chk("rnd_valid", out_valid, m_ov);
    chk("rnd_data", out_data, m_od);
    chk("rnd_lane", out_lane, m_ol);
    chk("rnd_ready", rdy, er);
    chk("rnd_busy", busy, anyf || m_ov);
`ifdef FOO_COLLECT_PARITY_EN
    chk("rnd_out_par", out_par, ^m_od);
`endif
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; v = '0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [31:0] dat;
    logic        ordy;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [1:0]  e_ol;
    logic [3:0]  e_rdy;
    logic        e_busy;
  } vec_t;

  vec_t tbl [13];

  initial begin
    // single lane, then backpressure with lanes 0/1 held behind a stalled lane-3 word
    tbl[0]  = '{4'b0100, 32'h00A5_0000, 1'b1, 1'b0, 8'h00, 2'd0, 4'b1011, 1'b1};
    tbl[1]  = '{4'b0000, 32'h0,         1'b1, 1'b1, 8'hA5, 2'd2, 4'b1111, 1'b1};
    tbl[2]  = '{4'b0000, 32'h0,         1'b1, 1'b0, 8'hA5, 2'd2, 4'b1111, 1'b0};
    tbl[3]  = '{4'b1000, 32'h3300_0000, 1'b0, 1'b0, 8'hA5, 2'd2, 4'b0111, 1'b1};
    tbl[4]  = '{4'b0011, 32'h0000_2211, 1'b0, 1'b1, 8'h33, 2'd3, 4'b1100, 1'b1};
    for (int r = 5; r < 10; r++)
      tbl[r] = '{4'b0000, 32'h0,        1'b0, 1'b1, 8'h33, 2'd3, 4'b1100, 1'b1};
    tbl[10] = '{4'b0000, 32'h0,         1'b1, 1'b1, 8'h11, 2'd0, 4'b1101, 1'b1};
    tbl[11] = '{4'b0000, 32'h0,         1'b1, 1'b1, 8'h22, 2'd1, 4'b1111, 1'b1};
    tbl[12] = '{4'b0000, 32'h0,         1'b1, 1'b0, 8'h22, 2'd1, 4'b1111, 1'b0};

    for (int i = 0; i < NL; i++) d[i] = '0;
    model_reset();

    // Reset with all lanes asserting valid
    v = '1; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_ready", rdy, 4'b0000);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_lane", out_lane, 2'd0);
    v = '0; rst_n = 1'b1;
    #1;
    chk("rst_release_ready", rdy, 4'b1111);

    // Directed table
    for (int r = 0; r < 13; r++) begin
      v = tbl[r].v;
      for (int l = 0; l < NL; l++) d[l] = tbl[r].dat[8*l +: 8];
      out_ready = tbl[r].ordy;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", r), out_valid, tbl[r].e_ov);
      chk($sformatf("tbl%0d_data", r), out_data, tbl[r].e_od);
      chk($sformatf("tbl%0d_lane", r), out_lane, tbl[r].e_ol);
      chk($sformatf("tbl%0d_ready", r), rdy, tbl[r].e_rdy);
      chk($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
    end

    // Fairness: all lanes continuously valid
    apply_reset();
    for (int i = 0; i < NL; i++) d[i] = 8'h10 + 8'(i);
    v = '1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("fair_first_valid", out_valid, 1'b0);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("fair_valid", out_valid, 1'b1);
      chk("fair_lane", out_lane, 32'(k % 4));
      chk("fair_data", out_data, 32'(8'h10 + 8'(k % 4)));
    end

    // Reset mid-stream with a presented word and three full holders
    apply_reset();
    d[0] = 8'h41; d[1] = 8'h42; d[2] = 8'h43; d[3] = 8'h44;
    v = 4'b0111; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    v = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    v = '0;
    chk("ms_valid", out_valid, 1'b1);
    chk("ms_data", out_data, 8'h41);
    chk("ms_ready", rdy, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("ms_rst_valid", out_valid, 1'b0);
    chk("ms_rst_data", out_data, 8'h00);
    chk("ms_rst_ready", rdy, 4'b0000);
    chk("ms_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("ms_stale_valid", out_valid, 1'b0);
      chk("ms_stale_busy", busy, 1'b0);
    end

    // Randomized traffic against the model
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NL; i++) begin
        v[i] = ($urandom_range(0, 1) == 1);
        d[i] = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk_model();
    end

`ifdef FOO_COLLECT_PARITY_EN
    chk("par_err_clean", par_err, 1'b0);
    apply_reset();
    d[0] = 8'h03; p_flip = 4'b0001; v = 4'b0001; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v = '0; p_flip = '0;
    @(posedge clk);
    @(negedge clk);
    chk("par_valid", out_valid, 1'b1);
    chk("par_data", out_data, 8'h03);
    chk("par_out_par", out_par, 1'b0);
    chk("par_err_set", par_err, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("par_err_sticky", par_err, 1'b1);
    end
    apply_reset();
    chk("par_err_reset", par_err, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
